// File: rtl/bch_chien_search_pkg.sv
// Shared BCH parameter set, types and GF(2^m) helpers for the Chien search slice.
package bch_chien_search_pkg;

    localparam int unsigned M        = 4;
    localparam int unsigned D        = 7;
    localparam int unsigned N        = 15;
    localparam int unsigned IRRPOL   = 19;
    localparam int unsigned T        = (D - 1) / 2;
    localparam int unsigned GfOrder  = (1 << M) - 1;
    localparam int unsigned PtrW     = 4;
    localparam int unsigned ErrNumW  = $clog2(T + 2);
    localparam int unsigned PosW     = $clog2(N);

    typedef logic [M-1:0]       data_t;
    typedef logic [PtrW-1:0]    ptr_t;
    typedef logic [ErrNumW-1:0] err_num_t;
    typedef logic [PosW-1:0]    pos_t;

    typedef enum logic [0:0] {
        StWait,
        StSearch
    } state_t;

    // Generator polynomial with the implicit x^m term dropped.
    localparam data_t    PolyLow   = data_t'(IRRPOL);
    localparam err_num_t ErrNumMax = err_num_t'(T + 1);

    function automatic data_t gf_mult(data_t a, data_t b);
        data_t acc;
        data_t sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < M; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PolyLow : '0);
        end
        return acc;
    endfunction

    function automatic data_t gf_pow(int unsigned e);
        data_t r;
        r = data_t'(1);
        for (int unsigned k = 0; k < GfOrder; k++) begin
            if (k < (e % GfOrder)) begin
                r = gf_mult(r, data_t'(2));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_chien_search_cell.sv
// One Chien term: holds lambda_i * alpha^(-i(n-1)) at load, multiplies by alpha^i per step.
module bch_chien_cell
    import bch_chien_search_pkg::*;
#(
    parameter int unsigned Idx = 0
) (
    input  logic  iclk,
    input  logic  ireset,
    input  logic  iclkena,
    input  logic  iload,
    input  logic  istep,
    input  data_t icoef,
    output data_t oterm
);

    // Start at position n-1 so the first evaluation covers the MSB of the codeword.
    localparam int unsigned InitExp  = (GfOrder - (Idx * (N - 1)) % GfOrder) % GfOrder;
    localparam data_t       InitMult = gf_pow(InitExp);
    localparam data_t       StepMult = gf_pow(Idx % GfOrder);

    data_t term_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            term_q <= '0;
        end else if (iclkena) begin
            if (iload) begin
                term_q <= gf_mult(icoef, InitMult);
            end else if (istep) begin
                term_q <= gf_mult(term_q, StepMult);
            end
        end
    end

    assign oterm = term_q;

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates the error locator at alpha^-p for p = n-1 down to 0, one per clock.
module bch_chien_search
    import bch_chien_search_pkg::*;
(
    input  logic     iclk,
    input  logic     ireset,
    input  logic     iclkena,
    input  logic     iloc_poly_val,
    input  data_t    iloc_poly [0:T],
    input  ptr_t     iloc_poly_ptr,
    input  logic     iloc_decfail,
    output logic     obusy,
    output logic     osop,
    output logic     oval,
    output logic     oeop,
    output logic     oerr,
    output ptr_t     optr,
    output err_num_t oerr_num,
    output logic     odecfail
);

    state_t   state_q;
    pos_t     pos_q;
    err_num_t root_cnt_q;
    err_num_t deg_q;
    logic     decfail_q;
    logic     lam0_zero_q;

    data_t    terms [0:T];
    data_t    term_sum;
    err_num_t deg_d;
    err_num_t root_cnt_d;
    logic     load;
    logic     step;
    logic     last;
    logic     hit;
    logic     decfail_d;

    // obusy also covers the oeop cycle, which is what drops a strobe coincident with oeop.
    assign load = iloc_poly_val && (state_q == StWait) && !obusy;
    assign step = (state_q == StSearch);
    assign last = (pos_q == pos_t'(N - 1));

    for (genvar gi = 0; gi <= T; gi++) begin : g_cell
        bch_chien_cell #(
            .Idx (gi)
        ) u_cell (
            .iclk    (iclk),
            .ireset  (ireset),
            .iclkena (iclkena),
            .iload   (load),
            .istep   (step),
            .icoef   (iloc_poly[gi]),
            .oterm   (terms[gi])
        );
    end

    always_comb begin
        term_sum = '0;
        for (int unsigned i = 0; i <= T; i++) begin
            term_sum = term_sum ^ terms[i];
        end
    end

    assign hit = (term_sum == '0);

    always_comb begin
        deg_d = '0;
        for (int unsigned i = 1; i <= T; i++) begin
            if (iloc_poly[i] != '0) begin
                deg_d = err_num_t'(i);
            end
        end
    end

    assign root_cnt_d = (hit && (root_cnt_q != ErrNumMax)) ? root_cnt_q + 1'b1 : root_cnt_q;
    assign decfail_d  = decfail_q || (root_cnt_d != deg_q) || lam0_zero_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q     <= StWait;
            pos_q       <= '0;
            root_cnt_q  <= '0;
            deg_q       <= '0;
            decfail_q   <= 1'b0;
            lam0_zero_q <= 1'b0;
            obusy       <= 1'b0;
            osop        <= 1'b0;
            oval        <= 1'b0;
            oeop        <= 1'b0;
            oerr        <= 1'b0;
            oerr_num    <= '0;
            odecfail    <= 1'b0;
        end else if (iclkena) begin
            osop <= 1'b0;
            oval <= 1'b0;
            oeop <= 1'b0;
            oerr <= 1'b0;
            if (oeop) begin
                obusy <= 1'b0;
            end
            unique case (state_q)
                StWait: begin
                    if (load) begin
                        state_q     <= StSearch;
                        obusy       <= 1'b1;
                        pos_q       <= '0;
                        root_cnt_q  <= '0;
                        deg_q       <= deg_d;
                        decfail_q   <= iloc_decfail;
                        lam0_zero_q <= (iloc_poly[0] == '0);
                    end
                end
                StSearch: begin
                    oval       <= 1'b1;
                    osop       <= (pos_q == '0);
                    oeop       <= last;
                    oerr       <= hit;
                    root_cnt_q <= root_cnt_d;
                    pos_q      <= pos_q + 1'b1;
                    if (last) begin
                        state_q  <= StWait;
                        oerr_num <= root_cnt_d;
                        odecfail <= decfail_d;
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

    // Pointer is pure payload; it is always written before it is observed.
    always_ff @(posedge iclk) begin
        if (iclkena && load) begin
            optr <= iloc_poly_ptr;
        end
    end

endmodule

// File: tb/tb_bch_chien_search.sv
// Self-checking bench for bch_chien_search: GF model feeds a scoreboard, monitor collects outputs.
module tb_bch_chien_search;

    typedef logic [3:0][3:0] poly_t;  // poly[i] is the x^i coefficient

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       err;
        logic [3:0] ptr;
        logic [2:0] num;
        logic       dfail;
    } rec_t;

    logic       iclk;
    logic       ireset;
    logic       iclkena;
    logic       iloc_poly_val;
    logic [3:0] loc_poly [0:3];
    logic [3:0] iloc_poly_ptr;
    logic       iloc_decfail;
    logic       obusy;
    logic       osop;
    logic       oval;
    logic       oeop;
    logic       oerr;
    logic [3:0] optr;
    logic [2:0] oerr_num;
    logic       odecfail;

    rec_t exp_q [$];
    rec_t obs_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bch_chien_search dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .iclkena       (iclkena),
        .iloc_poly_val (iloc_poly_val),
        .iloc_poly     (loc_poly),
        .iloc_poly_ptr (iloc_poly_ptr),
        .iloc_decfail  (iloc_decfail),
        .obusy         (obusy),
        .osop          (osop),
        .oval          (oval),
        .oeop          (oeop),
        .oerr          (oerr),
        .optr          (optr),
        .oerr_num      (oerr_num),
        .odecfail      (odecfail)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // A position transfers on an edge where oval and iclkena are both high.
    always @(negedge iclk) begin : monitor
        rec_t r;
        if (!ireset && iclkena && oval) begin
            r.sop   = osop;
            r.eop   = oeop;
            r.err   = oerr;
            r.ptr   = optr;
            r.num   = oeop ? oerr_num : 3'd0;
            r.dfail = oeop ? odecfail : 1'b0;
            obs_q.push_back(r);
        end
    end

    function automatic logic [3:0] tb_mul(logic [3:0] a, logic [3:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'b0, a} << i);
        for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] alpha_pow(int e);
        logic [3:0] r;
        r = 4'd1;
        for (int k = 0; k < e % 15; k++) r = tb_mul(r, 4'd2);
        return r;
    endfunction

    // Direct evaluation of lambda(alpha^-p) per position, pushed in output order.
    task automatic model_frame(input poly_t lam, input logic [3:0] ptr, input logic dec);
        int         cnt;
        int         deg;
        int         p;
        logic [3:0] x;
        logic [3:0] xp;
        logic [3:0] acc;
        logic       hit;
        rec_t       r;
        cnt = 0;
        deg = 0;
        for (int i = 1; i < 4; i++) if (lam[i] != 4'd0) deg = i;
        for (int j = 0; j < 15; j++) begin
            p   = 14 - j;
            x   = alpha_pow((15 - p) % 15);
            acc = 4'd0;
            xp  = 4'd1;
            for (int i = 0; i < 4; i++) begin
                acc = acc ^ tb_mul(lam[i], xp);
                xp  = tb_mul(xp, x);
            end
            hit = (acc == 4'd0);
            if (hit && cnt < 4) cnt++;
            r.sop   = (j == 0);
            r.eop   = (j == 14);
            r.err   = hit;
            r.ptr   = ptr;
            r.num   = (j == 14) ? 3'(cnt) : 3'd0;
            r.dfail = (j == 14) ? (dec | (cnt != deg) | (lam[0] == 4'd0)) : 1'b0;
            exp_q.push_back(r);
        end
    endtask

    // Called at posedge+#1; holds the strobe for exactly one edge.
    task automatic strobe(input poly_t lam, input logic [3:0] ptr, input logic dec,
                          input bit accepted);
        iloc_poly_val = 1'b1;
        for (int i = 0; i < 4; i++) loc_poly[i] = lam[i];
        iloc_poly_ptr = ptr;
        iloc_decfail  = dec;
        if (accepted) model_frame(lam, ptr, dec);
        @(posedge iclk);
        #1;
        iloc_poly_val = 1'b0;
        iloc_decfail  = 1'b0;
    endtask

    task automatic wait_obs(input int want, output bit timed_out);
        int c;
        c = 0;
        while (obs_q.size() < want && c < 300) begin
            @(posedge iclk);
            c++;
        end
        timed_out = (obs_q.size() < want);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iclk);
        #1;
        n_checks++;
        if ({obusy, osop, oval, oeop, oerr, odecfail, oerr_num} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_active: got %b required 0", {obusy, osop, oval, oeop, oerr,
                     odecfail, oerr_num});
        end
        ireset = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        n_checks++;
        if ({obusy, osop, oval, oeop, oerr, odecfail, oerr_num} !== 9'd0 || obs_q.size() != 0)
        begin
            n_fail++;
            $display("FAIL reset_idle: got %b with %0d outputs, required 0", {obusy, osop, oval,
                     oeop, oerr, odecfail, oerr_num}, obs_q.size());
        end
    endtask

    task automatic test_decode();
        poly_t       lams  [6];
        logic        decs  [6];
        logic [14:0] masks [6];
        logic [2:0]  nums  [6];
        logic        dfs   [6];
        bit          to;
        rec_t        o;
        rec_t        e;
        logic [14:0] mask;
        logic [2:0]  num;
        logic        df;
        lams[0] = {4'd0, 4'd0, 4'd0, 4'd1}; decs[0] = 0; masks[0] = 15'h0000; nums[0] = 0; dfs[0] = 0;
        lams[1] = {4'd0, 4'd0, 4'd8, 4'd1}; decs[1] = 0; masks[1] = 15'h0800; nums[1] = 1; dfs[1] = 0;
        lams[2] = {4'd0, 4'd9, 4'd8, 4'd1}; decs[2] = 0; masks[2] = 15'h4001; nums[2] = 2; dfs[2] = 0;
        lams[3] = {4'd0, 4'd8, 4'd1, 4'd1}; decs[3] = 0; masks[3] = 15'h0000; nums[3] = 0; dfs[3] = 1;
        lams[4] = {4'd0, 4'd0, 4'd0, 4'd1}; decs[4] = 1; masks[4] = 15'h0000; nums[4] = 0; dfs[4] = 1;
        lams[5] = {4'd0, 4'd0, 4'd0, 4'd0}; decs[5] = 0; masks[5] = 15'h7fff; nums[5] = 4; dfs[5] = 1;
        for (int c = 0; c < 6; c++) begin
            strobe(lams[c], 4'(c * 3 + 1), decs[c], 1'b1);
            wait_obs(15, to);
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL decode%0d_timeout: got %0d positions required 15", c, obs_q.size());
            end
            mask = '0;
            num  = '0;
            df   = 1'b0;
            for (int k = 0; k < 15 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.err) mask[k] = 1'b1;
                if (o.eop) begin
                    num = o.num;
                    df  = o.dfail;
                end
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL decode%0d_pos%0d: got %h required %h", c, k, o, e);
                end
            end
            exp_q.delete();
            n_checks++;
            if (mask !== masks[c] || num !== nums[c] || df !== dfs[c]) begin
                n_fail++;
                $display("FAIL decode%0d_summary: got mask %h num %0d dfail %b required %h %0d %b",
                         c, mask, num, df, masks[c], nums[c], dfs[c]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit          to;
        rec_t        o;
        rec_t        e;
        logic [14:0] mask_a;
        logic [14:0] mask_c;
        int          c;
        strobe({4'd0, 4'd0, 4'd8, 4'd1}, 4'h5, 1'b0, 1'b1);
        repeat (2) @(posedge iclk);
        #1;
        n_checks++;
        if (obusy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_mid: got %b required 1", obusy);
        end
        strobe({4'd0, 4'd0, 4'd0, 4'd0}, 4'h9, 1'b1, 1'b0);
        c = 0;
        while (oeop !== 1'b1 && c < 100) begin
            @(posedge iclk);
            #1;
            c++;
        end
        n_checks++;
        if (oeop !== 1'b1 || obusy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_eop_busy: got oeop %b obusy %b required 1 1", oeop, obusy);
        end
        strobe({4'd0, 4'd0, 4'd0, 4'd0}, 4'hA, 1'b1, 1'b0);
        n_checks++;
        if (obusy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_after_eop: got %b required 0", obusy);
        end
        strobe({4'd0, 4'd9, 4'd8, 4'd1}, 4'hC, 1'b0, 1'b1);
        wait_obs(30, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d positions required 30", obs_q.size());
        end
        mask_a = '0;
        mask_c = '0;
        for (int k = 0; k < 30 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.err && k < 15) mask_a[k] = 1'b1;
            if (o.err && k >= 15) mask_c[k - 15] = 1'b1;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_pos%0d: got %h required %h", k, o, e);
            end
        end
        exp_q.delete();
        n_checks++;
        if (mask_a !== 15'h0800 || mask_c !== 15'h4001) begin
            n_fail++;
            $display("FAIL b2b_masks: got %h %h required 0800 4001", mask_a, mask_c);
        end
        repeat (2) @(posedge iclk);
        #1;
    endtask

    task automatic test_clock_enable();
        bit         to;
        rec_t       o;
        rec_t       e;
        logic [4:0] snap;
        strobe({4'd0, 4'd9, 4'd8, 4'd1}, 4'h6, 1'b0, 1'b1);
        wait_obs(5, to);
        #1;
        iclkena = 1'b0;
        snap = {obusy, osop, oval, oeop, oerr};
        for (int k = 0; k < 4; k++) begin
            @(posedge iclk);
            #1;
            n_checks++;
            if ({obusy, osop, oval, oeop, oerr} !== snap || snap[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL clkena_hold%0d: got %b required %b with oval high", k,
                         {obusy, osop, oval, oeop, oerr}, snap);
            end
        end
        iclkena = 1'b1;
        wait_obs(15, to);
        repeat (4) @(posedge iclk);
        n_checks++;
        if (to || obs_q.size() != 15) begin
            n_fail++;
            $display("FAIL clkena_count: got %0d positions required 15", obs_q.size());
        end
        for (int k = 0; k < 15 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL clkena_pos%0d: got %h required %h", k, o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        #1;
    endtask

    task automatic test_reset_mid_frame();
        bit          to;
        rec_t        o;
        rec_t        e;
        logic [14:0] mask;
        strobe({4'd0, 4'd0, 4'd8, 4'd1}, 4'h7, 1'b0, 1'b1);
        wait_obs(7, to);
        #1;
        ireset = 1'b1;
        #1;
        n_checks++;
        if ({obusy, osop, oval, oeop, oerr, odecfail, oerr_num} !== 9'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b required 0", {obusy, osop, oval, oeop, oerr,
                     odecfail, oerr_num});
        end
        for (int k = 0; k < 7 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_pos%0d: got %h required %h", k, o, e);
            end
        end
        exp_q.delete();
        @(posedge iclk);
        #1;
        ireset = 1'b0;
        repeat (20) @(posedge iclk);
        #1;
        n_checks++;
        if (obs_q.size() != 0 || obusy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abandon: got %0d positions obusy %b required 0 0",
                     obs_q.size(), obusy);
        end
        obs_q.delete();
        strobe({4'd0, 4'd9, 4'd8, 4'd1}, 4'h2, 1'b0, 1'b1);
        wait_obs(15, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL midreset_timeout: got %0d positions required 15", obs_q.size());
        end
        mask = '0;
        for (int k = 0; k < 15 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.err) mask[k] = 1'b1;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_new_pos%0d: got %h required %h", k, o, e);
            end
        end
        n_checks++;
        if (mask !== 15'h4001) begin
            n_fail++;
            $display("FAIL midreset_new_mask: got %h required 4001", mask);
        end
        exp_q.delete();
    endtask

    initial begin
        iclkena       = 1'b1;
        ireset        = 1'b1;
        iloc_poly_val = 1'b0;
        iloc_poly_ptr = 4'd0;
        iloc_decfail  = 1'b0;
        for (int i = 0; i < 4; i++) loc_poly[i] = 4'd0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_clock_enable();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
